// File: rtl/serial_tx_unit.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_unit
// Purpose  : Byte-wide write port to UART (8N1, or 8E1 when SERIAL_TX_PARITY_EN
//            is defined) with a small FIFO absorbing bursts from the core.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_unit #(
    parameter int CLOCKS_PER_BIT = 543,
    parameter int FIFO_DEPTH     = 16,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  negResetIn,
    input  logic                  serialWE,
    input  logic [DATA_WIDTH-1:0] serialWriteData,
    output logic                  txd,
    output logic                  full,
    output logic                  busy,
    output logic                  overflow
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_BAUD_W = $clog2(CLOCKS_PER_BIT);
    localparam int c_IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_RELOAD = c_BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0]  c_LAST_BIT    = c_IDX_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL_COUNT  = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                r_state, w_stateNext;
    logic [c_BAUD_W-1:0]   r_baud, w_baudNext;
    logic [c_IDX_W-1:0]    r_bitIdx, w_bitIdxNext;
    logic [DATA_WIDTH-1:0] r_shift, w_shiftNext;
    logic [c_PTR_W-1:0]    r_rdPtr, r_wrPtr;
    logic [c_CNT_W-1:0]    r_count, w_countNext;
    logic                  r_full;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_push, w_pop, w_txd;
`ifdef SERIAL_TX_PARITY_EN
    logic                  r_parity, w_parityNext;
`endif

    assign w_push = serialWE && !r_full;
    assign w_head = r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= serialWriteData;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_baudNext   = (r_state == IDLE) ? r_baud : r_baud - c_BAUD_W'(1);
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_pop        = 1'b0;
        w_txd        = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        w_parityNext = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_shiftNext = w_head;
                    w_baudNext  = c_BAUD_RELOAD;
                    w_stateNext = START;
`ifdef SERIAL_TX_PARITY_EN
                    w_parityNext = ^w_head;
`endif
                end
            end
            START: begin
                w_txd = 1'b0;
                if (r_baud == '0) begin
                    w_baudNext   = c_BAUD_RELOAD;
                    w_bitIdxNext = '0;
                    w_stateNext  = DATA;
                end
            end
            DATA: begin
                w_txd = r_shift[0];
                if (r_baud == '0) begin
                    w_baudNext   = c_BAUD_RELOAD;
                    w_shiftNext  = r_shift >> 1;
                    w_bitIdxNext = r_bitIdx + c_IDX_W'(1);
                    if (r_bitIdx == c_LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        w_stateNext = PARITY;
`else
                        w_stateNext = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                w_txd = r_parity;
                if (r_baud == '0) begin
                    w_baudNext  = c_BAUD_RELOAD;
                    w_stateNext = STOP;
                end
            end
`endif
            STOP: begin
                if (r_baud == '0) begin
                    // Chain straight into the next start bit so frames abut.
                    if (r_count != '0) begin
                        w_pop       = 1'b1;
                        w_shiftNext = w_head;
                        w_baudNext  = c_BAUD_RELOAD;
                        w_stateNext = START;
`ifdef SERIAL_TX_PARITY_EN
                        w_parityNext = ^w_head;
`endif
                    end else begin
                        w_baudNext  = '0;
                        w_stateNext = IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_baudNext  = '0;
            end
        endcase
    end

    always_comb begin
        w_countNext = r_count;
        if (w_push && !w_pop) begin
            w_countNext = r_count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state  <= w_stateNext;
            r_baud   <= w_baudNext;
            r_bitIdx <= w_bitIdxNext;
            r_shift  <= w_shiftNext;
            r_count  <= w_countNext;
            r_full   <= (w_countNext == c_FULL_COUNT);
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= w_parityNext;
`endif
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            // A write against a full FIFO is lost even if a pop frees space this cycle.
            if (serialWE && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign txd      = w_txd;
    assign full     = r_full;
    assign busy     = (r_state != IDLE) || (r_count != '0);
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/serial_tx_unit.md
Name: serial_tx_unit

Overview:
- Converts the core's byte-wide serial write port (serialWE / serialWriteData) into an 8N1 UART bit stream on txd.
- Sits between the IO unit's serial output register and the board pin.
- A small FIFO absorbs bursts from the core while frames drain at baud rate.
- It is the wire-side producer whose output the simulation-side serial dumper and the host terminal consume.

Parameters:
- CLOCKS_PER_BIT, 543: clk cycles per UART bit (62.5 MHz / 115200). Legal range is ≥ 2.
- FIFO_DEPTH, 16: byte entries. Must be a power of 2, ≥ 2.
- DATA_WIDTH, 8: byte width, equal to SerialDataPath.

Ports:
- clk  in  1  core clock
- negResetIn  in  1  asynchronous active-low reset
- serialWE  in  1  byte write strobe, one byte per asserted cycle
- serialWriteData  in  DATA_WIDTH  byte to transmit
- txd  out  1  UART line; idles high
- full  out  1  FIFO holds FIFO_DEPTH entries (registered)
- busy  out  1  a frame is in progress or the FIFO is non-empty
- overflow  out  1  sticky: at least one write was dropped

Behaviour:
- Reset (negResetIn low, asynchronous):
  - txd=1, full=0, busy=0, overflow=0.
  - FIFO pointers and count = 0, FSM = IDLE, baud counter = 0, bit index = 0.
  - Reset mid-frame aborts the frame; txd returns high immediately.
- FIFO:
  - Push when serialWE && !full. The entry is visible to the FSM on the next cycle.
  - serialWE while full drops the byte and sets overflow, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
  - full = (count == FIFO_DEPTH). busy = (state != IDLE) || (count != 0).
- FSM states: IDLE, START, DATA, STOP (plus PARITY if enabled).
  - IDLE:
    - txd=1.
    - If count != 0: pop the head into the shift register, load the baud counter with CLOCKS_PER_BIT-1, go to START.
  - START:
    - txd=0 for CLOCKS_PER_BIT cycles.
    - When the counter reaches 0: reload the counter, bit index=0, go to DATA.
  - DATA:
    - txd = shift[0], LSB first.
    - On counter 0: shift right, reload the counter, and increment the bit index.
    - After bit DATA_WIDTH-1 go to STOP (or PARITY).
  - STOP:
    - txd=1 for CLOCKS_PER_BIT cycles.
    - On counter 0 with count != 0: pop, reload the counter, go directly to START, so the next start bit begins the following cycle with no extra idle.
    - On counter 0 with count == 0: go to IDLE.
- Timing:
  - Byte written at cycle N while IDLE and empty: FIFO entry at N+1, pop at N+1, txd falls at N+2.
  - Frame length is exactly (2+DATA_WIDTH)·CLOCKS_PER_BIT cycles (plus CLOCKS_PER_BIT with parity).
  - Back-to-back frames have zero gap.
- The baud counter decrements every cycle outside IDLE; no fractional baud.
- overflow clears only on reset.

Optional Feature:
- SERIAL_TX_PARITY_EN
  - Defined:
    - A PARITY state is inserted between DATA and STOP.
    - It drives txd = even parity (XOR of the byte) for CLOCKS_PER_BIT cycles.
    - Frame becomes 8E1, 11 bits.
  - Undefined:
    - No PARITY state exists; the frame is 8N1, 10 bits.
    - DATA goes straight to STOP.

Test Plan:
- Single byte (CLOCKS_PER_BIT=4):
  - Stimulus: serialWE=1, data=0x55 for one cycle at N.
  - Required: txd=0 on cycles N+2..N+5, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then stop=1 for 4 cycles. busy deasserts at N+42.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles -> frames are contiguous; the second start bit begins the cycle after the first stop bit's last cycle; sampled payload is 0x00, 0xFF.
- Overflow: with FIFO_DEPTH=4, write 6 bytes 0x10..0x15 in consecutive cycles.
  - full asserts; overflow=1.
  - Transmitted bytes are 0x10..0x14: 0x10 is popped into the frame, leaving room for 0x14; 0x15 is dropped.
- Simultaneous push/pop: write exactly on the STOP-to-START pop cycle with count=1 -> count stays 1; no byte is lost or duplicated.
- Reset mid-frame: drop negResetIn during DATA bit 3 -> txd=1 the same cycle, busy=0, full=0, overflow=0. After release, a new write of 0xA5 transmits a clean frame.
- Parity (SERIAL_TX_PARITY_EN): 0x07 -> parity bit=1 before the stop bit; 0x03 -> parity bit=0; frame length 44 cycles at CLOCKS_PER_BIT=4.
